// File: rtl/subtr_4bit_serial.sv
// Bit-serial ripple-borrow subtractor: diff = in1 - in2 - borrow_in, one bit per clock, LSB first.
// Ports: clk, rst_n | start, in1, in2, borrow_in -> busy, done, diff, borrow_out, overflow.
module subtr_4bit_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             bit_d;
    logic             br_d;

    // One full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= in1;
                        b_q     <= in2;
                        br_q    <= borrow_in;
                        a_msb_q <= in1[WIDTH-1];
                        b_msb_q <= in2[WIDTH-1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    // Result fills from the top so bit 0 ends up at the LSB.
                    res_q <= {bit_d, res_q[WIDTH-1:1]};
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // bit_d is the result MSB on the final cycle.
                        diff_q  <= {bit_d, res_q[WIDTH-1:1]};
                        bout_q  <= br_d;
                        ovf_q   <= (a_msb_q != b_msb_q) &&
                                   (bit_d != a_msb_q);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_subtr_4bit_serial.sv
// Testbench for subtr_4bit_serial: arithmetic reference model, per-cycle compare,
// plus literal expectations for known operand sets, handshake and reset cases.
module tb_subtr_4bit_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int n_vec = 0;
    int n_err = 0;

    subtr_4bit_serial #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in1(in1),
        .in2(in2),
        .borrow_in(bin),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrow_out(bout),
        .overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..W busy computing, W+1 done.
    int           ph = 0;
    int           m_a, m_b, m_bi;
    logic [W-1:0] e_diff = '0;
    logic         e_bo = 1'b0;
    logic         e_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            e_diff = '0;
            e_bo = 1'b0;
            e_ov = 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                m_a = int'(in1);
                m_b = int'(in2);
                m_bi = int'(bin);
                ph = 1;
            end
        end else if (ph < W) begin
            ph++;
        end else if (ph == W) begin
            int sa, sb, s;
            e_diff = W'((m_a - m_b - m_bi) & ((1 << W) - 1));
            e_bo = (m_a < m_b + m_bi);
            sa = (m_a >= (1 << (W - 1))) ? m_a - (1 << W) : m_a;
            sb = (m_b >= (1 << (W - 1))) ? m_b - (1 << W) : m_b;
            s = sa - sb - m_bi;
            e_ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
            ph = W + 1;
        end else begin
            ph = 0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("busy", int'(busy), int'(ph != 0));
            chk("done", int'(done), int'(ph == W + 1));
            chk("diff", int'(diff), int'(e_diff));
            chk("borrow_out", int'(bout), int'(e_bo));
            chk("overflow", int'(ovf), int'(e_ov));
        end
    end

    task automatic run_op(input int a, input int b, input int bi,
                          input bit lit, input int ed, input int eb,
                          input int eo);
        int cyc;
        bit got;
        @(negedge clk);
        in1 = W'(a);
        in2 = W'(b);
        bin = bi[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (done) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        chk("latency", got ? cyc : 99, W);
        if (lit) begin
            chk("lit_diff", int'(diff), ed);
            chk("lit_borrow", int'(bout), eb);
            chk("lit_ovf", int'(ovf), eo);
        end
        @(negedge clk);
    endtask

    initial begin
        int dones[$];
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(9, 3, 0, 1'b1, 6, 0, 1);
        run_op(3, 9, 0, 1'b1, 10, 1, 1);
        run_op(8, 1, 0, 1'b1, 7, 0, 1);
        run_op(0, 0, 1, 1'b1, 15, 1, 0);
        run_op(5, 2, 1, 1'b1, 2, 0, 0);

        // Start pulses during SUB and DONE must be ignored.
        @(negedge clk);
        in1 = 4'd9; in2 = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in1 = 4'd0; in2 = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("ign_busy", int'(busy), 0);
        chk("ign_diff", int'(diff), 6);
        @(negedge clk);

        // Start held high: a new operation every W+2 cycles.
        start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #2;
            if (done) dones.push_back(i);
            @(negedge clk);
            in1 = W'(i * 3 + 1);
            in2 = W'(i * 5 + 2);
            bin = i[0];
        end
        start = 1'b0;
        chk("held_ops", (dones.size() >= 3) ? 1 : 0, 1);
        for (int k = 1; k < dones.size(); k++)
            chk("held_period", dones[k] - dones[k-1], W + 2);
        repeat (8) @(negedge clk);

        // Reset after two bit cycles aborts without a done pulse.
        @(negedge clk);
        in1 = 4'd14; in2 = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_diff", int'(diff), 0);
        chk("mid_rst_bout", int'(bout), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_nodone", int'(done), 0);
        rst_n = 1'b1;
        run_op(5, 2, 1, 1'b1, 2, 0, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_op(a, b, c, 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
